// File: rtl/rgb_led_arbiter_if.sv
// Bundle of the request/colour/brightness inputs and the grant/LED outputs
// exchanged between the status sources and the shared RGB LED arbiter.
interface rgb_led_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int PWM_BITS = 8
);
  // level requests and {R,G,B} colour per source, source i at [3i+2:3i]
  logic [NUM_REQ-1:0]   req;
  logic [3*NUM_REQ-1:0] color;
  // global PWM duty shared by every owner
  logic [PWM_BITS-1:0]  bright;

  // ownership report
  logic [NUM_REQ-1:0]   grant;
  logic [2:0]           active_idx;
  logic                 busy;

  // LED pin drives, active-high
  logic                 rled;
  logic                 gled;
  logic                 bled;

  // status sources side
  modport master (
    output req, color, bright,
    input  grant, active_idx, busy, rled, gled, bled
  );

  // arbiter side
  modport slave (
    input  req, color, bright,
    output grant, active_idx, busy, rled, gled, bled
  );
endinterface

// File: rtl/rgb_led_arbiter.sv
// Shares the single RGB LED between NUM_REQ status sources.
// Round-robin arbitration, minimum dwell per owner when others are waiting,
// an optional dark gap between owners, and a global PWM brightness applied
// to the owner's colour latched at grant time.
module rgb_led_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DWELL_CYCLES = 2000000,
  parameter int GAP_CYCLES   = 20000,
  parameter int PWM_BITS     = 8
) (
  input  logic               clk_2m,
  input  logic               combo_reset,
  rgb_led_arbiter_if.slave   bus
);

  // Owner/pointer indices are always 3 bits so that up to 8 sources fit and
  // every per-source table below is padded out to 8 entries.
  localparam int IDX_W   = 3;
  localparam int SLOTS   = 1 << IDX_W;
  localparam int SUM_W   = IDX_W + 1;

  // Counters are sized to hold their terminal value and never wrap.
  localparam int DWELL_W = (DWELL_CYCLES > 0) ? $clog2(DWELL_CYCLES + 1) : 1;
  localparam int GAP_W   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  // gap_cnt value seen during the last dark cycle
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    GAP     = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     owner_reg, owner_next;
  logic [IDX_W-1:0]     ptr_reg, ptr_next;
  logic [2:0]           color_reg, color_next;
  logic [DWELL_W-1:0]   dwell_reg, dwell_next;
  logic [GAP_W-1:0]     gap_reg, gap_next;
  logic [PWM_BITS-1:0]  pwm_reg;
  logic [2:0]           led_reg;

  // Per-source tables padded to SLOTS entries; unused slots never request.
  logic [SLOTS-1:0]     req_pad;
  logic [2:0]           color_arr [SLOTS];

  // Round-robin candidates: cand_idx[k] is source (ptr+1+k) mod NUM_REQ.
  logic [IDX_W-1:0]     cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0]   cand_req;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;

  logic                 owner_req;
  logic                 others_req;
  logic [SLOTS-1:0]     owner_mask;
  logic [DWELL_W-1:0]   dwell_inc;
  logic                 dwell_done;
  logic                 gap_last;
  logic                 take;

  genvar gi;

  // Pad request and colour inputs to the full index range.
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_pad
      if (gi < NUM_REQ) begin : g_used
        assign req_pad[gi]   = bus.req[gi];
        assign color_arr[gi] = bus.color[3*gi +: 3];
      end else begin : g_unused
        assign req_pad[gi]   = 1'b0;
        assign color_arr[gi] = 3'b000;
      end
    end
  endgenerate

  // Rotate the search order so it starts just after the last owner.
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [SUM_W-1:0] sum;
      assign sum = {1'b0, ptr_reg} + SUM_W'(gi + 1);
      // ptr < NUM_REQ, so a single conditional subtract gives the modulo
      assign cand_idx[gi] = (sum >= SUM_W'(NUM_REQ)) ? IDX_W'(sum - SUM_W'(NUM_REQ))
                                                     : sum[IDX_W-1:0];
      assign cand_req[gi] = req_pad[cand_idx[gi]];
    end
  endgenerate

  // Pick the first requesting candidate in round-robin order.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        win_found = 1'b1;
        win_idx   = cand_idx[k];
      end
    end
  end

  // Owner and competitor status plus counter terminal conditions.
  always_comb begin
    owner_mask = SLOTS'(1) << owner_reg;
    owner_req  = |(req_pad & owner_mask);
    others_req = |(req_pad & ~owner_mask);
    // dwell_inc is the count including the current cycle, so the owner is
    // released on the edge that completes DWELL_CYCLES cycles of ownership
    dwell_inc  = (dwell_reg >= DWELL_W'(DWELL_CYCLES)) ? dwell_reg
                                                       : dwell_reg + DWELL_W'(1);
    dwell_done = (dwell_inc >= DWELL_W'(DWELL_CYCLES));
    gap_last   = (gap_reg >= GAP_W'(GAP_LAST));
  end

  // Next-state logic: grant, release, preempt and gap timing.
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    ptr_next   = ptr_reg;
    color_next = color_reg;
    dwell_next = dwell_reg;
    gap_next   = gap_reg;
    take       = 1'b0;

    unique case (state_reg)
      IDLE: begin
        take = win_found;
      end

      GRANTED: begin
        // an owner drop wins over a simultaneous dwell expiry; both release
        if (!owner_req || (dwell_done && others_req)) begin
          if (GAP_CYCLES > 0) begin
            state_next = GAP;
            gap_next   = '0;
          end else if (owner_req) begin
            // preempted with no gap: hand straight over to the next source
            take = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          dwell_next = dwell_inc;
        end
      end

      GAP: begin
        if (gap_last) begin
          if (win_found) begin
            take = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          gap_next = gap_reg + GAP_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // every entry to GRANTED moves the pointer and latches the colour
    if (take) begin
      state_next = GRANTED;
      owner_next = win_idx;
      ptr_next   = win_idx;
      color_next = color_arr[win_idx];
      dwell_next = '0;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk_2m or posedge combo_reset) begin
    if (combo_reset) begin
      state_reg <= IDLE;
      owner_reg <= '0;
      ptr_reg   <= IDX_W'(NUM_REQ - 1);
      color_reg <= 3'b000;
      dwell_reg <= '0;
      gap_reg   <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      ptr_reg   <= ptr_next;
      color_reg <= color_next;
      dwell_reg <= dwell_next;
      gap_reg   <= gap_next;
    end
  end

  // Free-running PWM counter.
  always_ff @(posedge clk_2m or posedge combo_reset) begin
    if (combo_reset) begin
      pwm_reg <= '0;
    end else begin
      pwm_reg <= pwm_reg + PWM_BITS'(1);
    end
  end

  // Registered LED drive: latched colour gated by the PWM duty while owned.
  always_ff @(posedge clk_2m or posedge combo_reset) begin
    if (combo_reset) begin
      led_reg <= 3'b000;
    end else if (state_reg == GRANTED) begin
      led_reg <= color_reg & {3{pwm_reg < bus.bright}};
    end else begin
      led_reg <= 3'b000;
    end
  end

  // One-hot grant decoded from the owner while in GRANTED.
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_grant
      assign bus.grant[gi] = (state_reg == GRANTED) && (owner_reg == IDX_W'(gi));
    end
  endgenerate

  assign bus.busy       = (state_reg == GRANTED);
  assign bus.active_idx = owner_reg;
  assign bus.rled       = led_reg[2];
  assign bus.gled       = led_reg[1];
  assign bus.bled       = led_reg[0];

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Directed plus randomized bench for rgb_led_arbiter, checked every cycle
// against a behavioural model of owner / dark-gap / PWM timing.
module tb_rgb_led_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int DWELL    = 8;
  localparam int GAP      = 2;
  localparam int PWM_BITS = 4;
  localparam int PWM_MOD  = 1 << PWM_BITS;

  logic clk_2m      = 1'b0;
  logic combo_reset = 1'b1;

  rgb_led_arbiter_if #(.NUM_REQ(NUM_REQ), .PWM_BITS(PWM_BITS)) bus_if ();

  rgb_led_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DWELL_CYCLES(DWELL),
    .GAP_CYCLES(GAP),
    .PWM_BITS(PWM_BITS)
  ) dut (
    .clk_2m(clk_2m),
    .combo_reset(combo_reset),
    .bus(bus_if)
  );

  always #5 clk_2m = ~clk_2m;

  int n_checks = 0;
  int n_pass   = 0;

  // behavioural model: owner (-1 = nobody), cycles owned, dark cycles left
  int         m_owner;
  int         m_last;
  int         m_held;
  int         m_dark;
  int         m_idx;
  int         m_pwm;
  logic [2:0] m_col;
  logic [2:0] m_led;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = NUM_REQ - 1;
    m_held  = 0;
    m_dark  = 0;
    m_idx   = 0;
    m_pwm   = 0;
    m_col   = 3'b000;
    m_led   = 3'b000;
  endtask

  // hand the LED to the first requester after the previous owner, if any
  task automatic model_pick();
    logic [3*NUM_REQ-1:0] cv;
    cv = bus_if.color;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int w;
      w = (m_last + k) % NUM_REQ;
      if (m_owner < 0 && bus_if.req[w]) begin
        m_owner = w;
        m_last  = w;
        m_idx   = w;
        m_held  = 0;
        m_col   = cv[3*w +: 3];
      end
    end
  endtask

  // advance the model by one clock edge using the inputs present at that edge
  task automatic model_step();
    logic [2:0] led_new;
    logic [NUM_REQ-1:0] others;
    led_new = (m_owner >= 0 && m_pwm < int'(bus_if.bright)) ? m_col : 3'b000;
    m_pwm   = (m_pwm + 1) % PWM_MOD;
    if (m_owner >= 0) begin
      m_held++;
      others = bus_if.req & ~(NUM_REQ'(1) << m_owner);
      if (!bus_if.req[m_owner] || (m_held >= DWELL && others != '0)) begin
        m_owner = -1;
        m_dark  = GAP;
        if (m_dark == 0) model_pick();
      end
    end else if (m_dark > 0) begin
      m_dark--;
      if (m_dark == 0) model_pick();
    end else begin
      model_pick();
    end
    m_led = led_new;
  endtask

  task automatic compare_model();
    logic [NUM_REQ-1:0] exp_grant;
    exp_grant = (m_owner >= 0) ? (NUM_REQ'(1) << m_owner) : '0;
    chk("grant", bus_if.grant, exp_grant);
    chk("busy", bus_if.busy, (m_owner >= 0));
    if (m_owner >= 0) chk("active_idx", bus_if.active_idx, m_idx);
    chk("leds", {bus_if.rled, bus_if.gled, bus_if.bled}, m_led);
  endtask

  task automatic tick();
    @(posedge clk_2m);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic set_color(input int src, input logic [2:0] c);
    logic [3*NUM_REQ-1:0] cv;
    cv = bus_if.color;
    cv[3*src +: 3] = c;
    bus_if.color = cv;
  endtask

  initial begin
    int cnt_a;
    int cnt_b;
    int waited;

    bus_if.req    = '0;
    bus_if.color  = '0;
    bus_if.bright = '0;
    model_reset();

    // reset values while combo_reset is held
    #12;
    chk("rst_grant", bus_if.grant, 4'b0000);
    chk("rst_busy", bus_if.busy, 1'b0);
    chk("rst_active_idx", bus_if.active_idx, 3'd0);
    chk("rst_leds", {bus_if.rled, bus_if.gled, bus_if.bled}, 3'b000);
    @(negedge clk_2m);
    combo_reset = 1'b0;

    // 1+2: sources 0 and 2 alternate with dwell and dark gaps
    bus_if.req    = 4'b0101;
    bus_if.bright = 4'd15;
    set_color(0, 3'b100);
    set_color(2, 3'b010);
    tick();
    chk("t1_first_grant", bus_if.grant, 4'b0001);
    run(45);

    // 3: sole requester keeps the LED with no gap; duty 15/16
    bus_if.req = 4'b0010;
    set_color(1, 3'b100);
    run(6);
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 48; i++) begin
      tick();
      if (bus_if.grant == 4'b0010) cnt_a++;
      if (bus_if.rled) cnt_b++;
    end
    chk("t3_grant_cycles", cnt_a, 48);
    chk("t3_rled_on", cnt_b, 45);

    // 4: brightness 0 keeps LEDs dark, 8 gives half duty
    bus_if.bright = 4'd0;
    run(1);
    cnt_a = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if ({bus_if.rled, bus_if.gled, bus_if.bled} != 3'b000) cnt_a++;
    end
    chk("t4_dark_at_0", cnt_a, 0);
    bus_if.bright = 4'd8;
    run(1);
    cnt_a = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus_if.rled) cnt_a++;
    end
    chk("t4_half_duty", cnt_a, 8);

    // 5: colour change mid-grant ignored until re-grant
    set_color(1, 3'b001);
    cnt_a = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus_if.bled) cnt_a++;
    end
    chk("t5_old_colour", cnt_a, 0);
    bus_if.req = 4'b0000;
    run(4);
    chk("t5_idle_grant", bus_if.grant, 4'b0000);
    bus_if.req = 4'b0010;
    run(3);
    cnt_a = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus_if.bled) cnt_a++;
    end
    chk("t5_new_colour", cnt_a, 8);

    // 6: async reset while source 3 owns, then all request
    bus_if.req    = 4'b1000;
    bus_if.bright = 4'd15;
    set_color(3, 3'b011);
    waited = 0;
    while (bus_if.grant != 4'b1000 && waited < 20) begin
      tick();
      waited++;
    end
    chk("t6_owner3", bus_if.grant, 4'b1000);
    run(3);
    #2;
    combo_reset = 1'b1;
    #1;
    model_reset();
    chk("t6_async_grant", bus_if.grant, 4'b0000);
    chk("t6_async_busy", bus_if.busy, 1'b0);
    chk("t6_async_leds", {bus_if.rled, bus_if.gled, bus_if.bled}, 3'b000);
    @(negedge clk_2m);
    @(negedge clk_2m);
    combo_reset = 1'b0;
    bus_if.req  = 4'b1111;
    tick();
    chk("t6_restart_src0", bus_if.grant, 4'b0001);
    run(40);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) bus_if.req = NUM_REQ'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) bus_if.color = (3*NUM_REQ)'($urandom);
      if ($urandom_range(0, 19) == 0) bus_if.bright = PWM_BITS'($urandom_range(0, 15));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
